ctrl_seq: RTL and testbench
===========================

Name: ctrl_seq

Overview:
Multi-cycle instruction sequencer for the 16-bit RISC datapath. It sits directly upstream of the datapath source mux (muxd) and drives that mux's select input. It also drives the IR, PC, register-file, ALU and memory strobes through a fetch/decode/execute/memory/writeback FSM. Memory accesses wait on a ready handshake guarded by a timeout, and the block keeps a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, consecutive mem_ready-low cycles tolerated in FETCH/MEM before abort; 0 disables the timeout
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
start  input  1  leave IDLE and begin fetching; ignored in all other states
instr_in  input  16  current IR contents; opcode = instr_in[15:12]
mem_ready  input  1  memory handshake: access completes in the cycle it is high
sel_out  output  2  drives muxd sel_in: 0=ALU result, 1=memory data, 2=immediate; 3 never driven
ir_load  output  1  load IR from memory bus
pc_inc  output  1  PC += 1
pc_load  output  1  PC <= jump target
rf_we  output  1  register-file write enable for the muxd output
alu_op  output  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
mem_rd  output  1  memory read request
mem_wr  output  1  memory write request
busy  output  1  high in every state except IDLE and HALT
halted  output  1  high in HALT
illegal  output  1  sticky: halted on an undefined opcode
timeout  output  1  sticky: halted on a memory timeout
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset values: FSM=IDLE, sel_out=0, alu_op=0, instret=0, illegal=0, timeout=0, wait counter=0. All strobes low.
- A reset asserted mid-operation aborts any in-flight access. mem_rd/mem_wr are low in the cycle after rst is sampled high.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 LDI
  - 7 LD
  - 8 ST
  - 9 JMP
  - F HALT
  - 0xA-0xE are illegal.
- sel_out and alu_op are registered in DECODE and held until the next DECODE. sel_out=0 for ALU ops, 1 for LD, 2 for LDI; sel_out is unchanged for all other opcodes.
- IDLE: if start=1, go to FETCH.
- FETCH:
  - mem_rd=1.
  - In a cycle with mem_ready=1: ir_load=1 and pc_inc=1 in that same cycle (Mealy), then go to DECODE.
- DECODE (1 cycle):
  - NOP: go to FETCH.
  - ALU ops: go to EXEC.
  - LDI: go to WB.
  - LD/ST: go to MEM.
  - JMP: pc_load=1 this cycle, then go to FETCH.
  - HALT: go to HALT.
  - Illegal opcode: illegal<=1, go to HALT.
- EXEC (1 cycle): alu_op valid, go to WB.
- MEM:
  - LD: mem_rd=1 until mem_ready, then go to WB.
  - ST: mem_wr=1 until mem_ready, then go to FETCH.
  - mem_rd and mem_wr are never high together.
- WB (1 cycle): rf_we=1 with sel_out valid, then go to FETCH.
- HALT: absorbing until rst; start is ignored; all strobes low.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments on each cycle there with mem_ready=0.
  - If mem_ready is low for MEM_TIMEOUT consecutive cycles, the next state is HALT, timeout<=1, and strobes drop.
  - mem_ready arriving in the same cycle as the MEM_TIMEOUT-th low-wait evaluation does not count (it has priority loss: the abort is taken).
  - mem_ready arriving on wait cycle MEM_TIMEOUT-1 or earlier completes normally.
- instret increments once per retired instruction:
  - on the DECODE exit for NOP and JMP
  - on the MEM exit for ST
  - on the WB exit for all other writeback instructions
  - HALT and illegal opcodes do not count.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Latency with mem_ready tied high:
  - NOP/JMP: 2 cycles
  - LDI/ST: 3 cycles
  - ALU ops/LD: 4 cycles
  - Each memory wait cycle adds 1.

Test Plan:
- Reset then start, instr_in=0x1xxx, mem_ready=1 -> FETCH, DECODE, EXEC, WB over 4 cycles. ir_load and pc_inc pulse in cycle 1; rf_we=1 with sel_out=0 and alu_op=0 in cycle 4; instret=1.
- LDI (0x6xxx) then LD (0x7xxx) with mem_ready delayed 3 cycles in MEM -> first WB has sel_out=2. LD holds mem_rd for 4 cycles, then WB with sel_out=1. instret=2.
- ST (0x8xxx) -> mem_wr high until mem_ready; no rf_we; returns to FETCH. JMP (0x9xxx) -> single pc_load pulse in DECODE, 2-cycle latency.
- mem_ready held low in FETCH, MEM_TIMEOUT=15 -> after 15 wait cycles: halted=1, timeout=1, mem_rd=0, busy=0. start ignored until rst, after which all outputs return to reset values.
- Opcode 0xB -> illegal=1, halted=1, instret unchanged. Opcode 0xF -> halted=1, illegal=0.
- Preload-free wrap check with CNT_W=4: 16 NOPs -> instret wraps to 0. rst asserted during MEM of an LD -> IDLE next cycle, mem_rd low, rf_we never pulses.

Source files
------------

// File: rtl/ctrl_seq_if.sv
// Control bundle between the instruction sequencer and the datapath/memory side.
// The master is the sequencer; the slave is the datapath and memory environment.
interface ctrl_seq_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [15:0]      instr_in;
    logic             mem_ready;
    logic [1:0]       sel_out;
    logic             ir_load;
    logic             pc_inc;
    logic             pc_load;
    logic             rf_we;
    logic [2:0]       alu_op;
    logic             mem_rd;
    logic             mem_wr;
    logic             busy;
    logic             halted;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] instret;

    modport master (
        input  start, instr_in, mem_ready,
        output sel_out, ir_load, pc_inc, pc_load, rf_we, alu_op,
               mem_rd, mem_wr, busy, halted, illegal, timeout, instret
    );

    modport slave (
        output start, instr_in, mem_ready,
        input  sel_out, ir_load, pc_inc, pc_load, rf_we, alu_op,
               mem_rd, mem_wr, busy, halted, illegal, timeout, instret
    );
endinterface

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute/memory/writeback sequencer for the 16-bit RISC datapath.
// Drives the muxd select, IR/PC/RF/ALU/memory strobes and a retired-instruction counter.
module ctrl_seq #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_IMM = 2'd2;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t            state_q;
    logic [1:0]        sel_q;
    logic [2:0]        alu_q;
    logic [CNT_W-1:0]  instret_q;
    logic              illegal_q;
    logic              timeout_q;
    logic [WAIT_W-1:0] wait_q;
    logic              is_st_q;

    logic [3:0]        opcode;
    logic              expired;
    logic [WAIT_W-1:0] wait_inc;
    logic              unused_operand;

    assign opcode = bus.instr_in[15:12];
    // The operand field belongs to the datapath; only the opcode steers sequencing.
    assign unused_operand = ^bus.instr_in[11:0];

    // A ready arriving on the cycle the limit is reached loses to the abort.
    assign expired  = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);
    assign wait_inc = (MEM_TIMEOUT == 0) ? wait_q : wait_q + 1'b1;

    // NOTE: reset is synchronous, so rst is tested inside the clocked block and
    // stays out of the sensitivity list; all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= SEL_ALU;
            alu_q     <= 3'd0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
            is_st_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_FETCH;
                        wait_q  <= '0;
                    end
                end
                S_FETCH: begin
                    if (expired) begin
                        state_q   <= S_HALT;
                        timeout_q <= 1'b1;
                    end else if (bus.mem_ready) begin
                        state_q <= S_DECODE;
                    end else begin
                        wait_q <= wait_inc;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOP, OP_JMP: begin
                            state_q   <= S_FETCH;
                            wait_q    <= '0;
                            instret_q <= instret_q + 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            sel_q   <= SEL_ALU;
                            alu_q   <= opcode[2:0] - 3'd1;
                            state_q <= S_EXEC;
                        end
                        OP_LDI: begin
                            sel_q   <= SEL_IMM;
                            state_q <= S_WB;
                        end
                        OP_LD, OP_ST: begin
                            if (opcode == OP_LD) begin
                                sel_q <= SEL_MEM;
                            end
                            is_st_q <= (opcode == OP_ST);
                            state_q <= S_MEM;
                            wait_q  <= '0;
                        end
                        OP_HALT: begin
                            state_q <= S_HALT;
                        end
                        default: begin
                            illegal_q <= 1'b1;
                            state_q   <= S_HALT;
                        end
                    endcase
                end
                S_EXEC: begin
                    state_q <= S_WB;
                end
                S_MEM: begin
                    if (expired) begin
                        state_q   <= S_HALT;
                        timeout_q <= 1'b1;
                    end else if (bus.mem_ready) begin
                        if (is_st_q) begin
                            state_q   <= S_FETCH;
                            wait_q    <= '0;
                            instret_q <= instret_q + 1'b1;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else begin
                        wait_q <= wait_inc;
                    end
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    wait_q    <= '0;
                    instret_q <= instret_q + 1'b1;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // IR load, PC increment and jump strobes act in the same cycle as their trigger.
    assign bus.ir_load = (state_q == S_FETCH) && bus.mem_ready && !expired;
    assign bus.pc_inc  = (state_q == S_FETCH) && bus.mem_ready && !expired;
    assign bus.pc_load = (state_q == S_DECODE) && (opcode == OP_JMP);

    assign bus.mem_rd  = (state_q == S_FETCH) || ((state_q == S_MEM) && !is_st_q);
    assign bus.mem_wr  = (state_q == S_MEM) && is_st_q;
    assign bus.rf_we   = (state_q == S_WB);
    assign bus.busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted  = (state_q == S_HALT);

    assign bus.sel_out = sel_q;
    assign bus.alu_op  = alu_q;
    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;
    assign bus.instret = instret_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: instruction-level schedule model, vector table, corner sequences,
// and a narrow-counter twin instance that shares the stimulus to observe wrap-around.
module tb_ctrl_seq;
    localparam int unsigned T = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_seq_if #(.CNT_W(16)) bus ();
    ctrl_seq_if #(.CNT_W(4))  bus_w ();

    assign bus_w.start     = bus.start;
    assign bus_w.instr_in  = bus.instr_in;
    assign bus_w.mem_ready = bus.mem_ready;

    ctrl_seq #(.MEM_TIMEOUT(T), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    ctrl_seq #(.MEM_TIMEOUT(T), .CNT_W(4)) u_dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.master)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [2:0]  alu;
        logic        ir_load;
        logic        pc_inc;
        logic        pc_load;
        logic        rf_we;
        logic        mem_rd;
        logic        mem_wr;
        logic        busy;
        logic        halted;
        logic        illegal;
        logic        timeout;
        logic [15:0] instret;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        int          fw;
        int          mw;
        logic [1:0]  sel;
        logic [2:0]  alu;
        logic [15:0] instret;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural view of the sequencer kept by the bench.
    logic [1:0]  m_sel;
    logic [2:0]  m_alu;
    logic [15:0] m_instret;
    logic        m_illegal;
    logic        m_timeout;
    logic        m_halted;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t base();
        obs_t e;
        e = '0;
        e.sel     = m_sel;
        e.alu     = m_alu;
        e.illegal = m_illegal;
        e.timeout = m_timeout;
        e.instret = m_instret;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.sel     = bus.sel_out;
        s.alu     = bus.alu_op;
        s.ir_load = bus.ir_load;
        s.pc_inc  = bus.pc_inc;
        s.pc_load = bus.pc_load;
        s.rf_we   = bus.rf_we;
        s.mem_rd  = bus.mem_rd;
        s.mem_wr  = bus.mem_wr;
        s.busy    = bus.busy;
        s.halted  = bus.halted;
        s.illegal = bus.illegal;
        s.timeout = bus.timeout;
        s.instret = bus.instret;
        return s;
    endfunction

    function automatic void model_reset();
        m_sel     = 2'd0;
        m_alu     = 3'd0;
        m_instret = 16'd0;
        m_illegal = 1'b0;
        m_timeout = 1'b0;
        m_halted  = 1'b0;
    endfunction

    // Entered at posedge+1 with this cycle's inputs applied; leaves at the next posedge+1.
    task automatic cyc(input string name, input obs_t e);
        #3;
        check(name, sample(), e);
        check({name, "_w"}, bus_w.instret, e.instret[3:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic halt_cycle(input string name);
        obs_t e;
        bus.mem_ready = 1'($urandom);
        bus.start     = 1'($urandom);
        e = base();
        e.halted = 1'b1;
        cyc(name, e);
        bus.start = 1'b0;
    endtask

    // Memory wait: ready arrives after 'waits' low cycles; at T low cycles the access aborts.
    task automatic mem_phase(input string name, input int waits, input bit is_rd,
                             input bit is_fetch, output bit ok);
        obs_t e;
        ok = 1'b0;
        for (int c = 0; c <= int'(T); c++) begin
            bus.mem_ready = (c >= waits);
            e = base();
            e.busy   = 1'b1;
            e.mem_rd = is_rd;
            e.mem_wr = !is_rd;
            if (c == int'(T)) begin
                cyc({name, "_abort"}, e);
                m_timeout = 1'b1;
                m_halted  = 1'b1;
                halt_cycle({name, "_to_halt"});
                return;
            end
            if (c == waits) begin
                e.ir_load = is_fetch;
                e.pc_inc  = is_fetch;
                cyc({name, "_done"}, e);
                ok = 1'b1;
                return;
            end
            cyc({name, "_wait"}, e);
        end
    endtask

    // One instruction from its first FETCH cycle to the first cycle of the next FETCH (or HALT).
    task automatic run_instr(input logic [15:0] word, input int fw, input int mw);
        obs_t       e;
        bit         ok;
        logic [3:0] op;
        op = word[15:12];
        bus.instr_in = word;
        mem_phase("fetch", fw, 1'b1, 1'b1, ok);
        if (!ok) return;
        bus.mem_ready = 1'($urandom);
        e = base();
        e.busy    = 1'b1;
        e.pc_load = (op == 4'h9);
        cyc("decode", e);
        if (op == 4'h0 || op == 4'h9) begin
            m_instret++;
        end else if (op >= 4'h1 && op <= 4'h5) begin
            m_sel = 2'd0;
            case (op)
                4'h1:    m_alu = 3'd0;
                4'h2:    m_alu = 3'd1;
                4'h3:    m_alu = 3'd2;
                4'h4:    m_alu = 3'd3;
                default: m_alu = 3'd4;
            endcase
            e = base();
            e.busy = 1'b1;
            cyc("exec", e);
            e.rf_we = 1'b1;
            cyc("wb_alu", e);
            m_instret++;
        end else if (op == 4'h6) begin
            m_sel = 2'd2;
            e = base();
            e.busy  = 1'b1;
            e.rf_we = 1'b1;
            cyc("wb_ldi", e);
            m_instret++;
        end else if (op == 4'h7) begin
            m_sel = 2'd1;
            mem_phase("mem_ld", mw, 1'b1, 1'b0, ok);
            if (!ok) return;
            bus.mem_ready = 1'($urandom);
            e = base();
            e.busy  = 1'b1;
            e.rf_we = 1'b1;
            cyc("wb_ld", e);
            m_instret++;
        end else if (op == 4'h8) begin
            mem_phase("mem_st", mw, 1'b0, 1'b0, ok);
            if (ok) m_instret++;
        end else if (op == 4'hF) begin
            m_halted = 1'b1;
            halt_cycle("halt_op");
        end else begin
            m_illegal = 1'b1;
            m_halted  = 1'b1;
            halt_cycle("illegal_op");
        end
    endtask

    task automatic do_reset();
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc("reset_idle", base());
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc("idle_start", base());
        bus.start = 1'b0;
    endtask

    vec_t tbl[11];

    initial begin
        obs_t        e;
        bit          ok;
        logic [3:0]  op;
        int          r;

        tbl = '{
            '{16'h1234,  0,  0, 2'd0, 3'd0, 16'd1},
            '{16'h6abc,  0,  0, 2'd2, 3'd0, 16'd2},
            '{16'h7001,  1,  3, 2'd1, 3'd0, 16'd3},
            '{16'h8002,  0,  2, 2'd1, 3'd0, 16'd4},
            '{16'h9003,  2,  0, 2'd1, 3'd0, 16'd5},
            '{16'h2000,  0,  0, 2'd0, 3'd1, 16'd6},
            '{16'h5fff, 14,  0, 2'd0, 3'd4, 16'd7},
            '{16'h0000,  0,  0, 2'd0, 3'd4, 16'd8},
            '{16'h7abc,  0, 14, 2'd1, 3'd4, 16'd9},
            '{16'h4000,  3,  0, 2'd0, 3'd3, 16'd10},
            '{16'h3000,  0,  0, 2'd0, 3'd2, 16'd11}
        };

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.instr_in  = 16'h0000;
        bus.mem_ready = 1'b0;
        model_reset();

        // Vector table: each entry runs one instruction and checks the held outputs afterwards.
        do_reset();
        do_start();
        for (int i = 0; i < 11; i++) begin
            run_instr(tbl[i].instr, tbl[i].fw, tbl[i].mw);
            check($sformatf("tbl%0d_sel", i), bus.sel_out, tbl[i].sel);
            check($sformatf("tbl%0d_alu", i), bus.alu_op, tbl[i].alu);
            check($sformatf("tbl%0d_instret", i), bus.instret, tbl[i].instret);
        end

        // Fetch timeout where ready arrives on the limit cycle: abort wins; start then ignored.
        do_reset();
        do_start();
        run_instr(16'h1000, T, 0);
        check("fetch_to_timeout", bus.timeout, 1'b1);
        check("fetch_to_busy", bus.busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bus.start = 1'b1;
            e = base();
            e.halted = 1'b1;
            cyc("halt_ignores_start", e);
        end
        do_reset();
        check("reset_clears_timeout", bus.timeout, 1'b0);

        // Store timeout in MEM.
        do_start();
        run_instr(16'h8000, 0, T);
        check("st_to_wr_low", bus.mem_wr, 1'b0);

        // Illegal opcode after one retired NOP, then HALT opcode.
        do_reset();
        do_start();
        run_instr(16'h0000, 0, 0);
        run_instr(16'hB123, 0, 0);
        check("illegal_flag", bus.illegal, 1'b1);
        check("illegal_instret", bus.instret, 16'd1);
        do_reset();
        do_start();
        run_instr(16'hF000, 1, 0);
        check("halt_illegal_clear", bus.illegal, 1'b0);
        check("halt_halted", bus.halted, 1'b1);

        // 16 NOPs wrap the 4-bit twin counter back to zero.
        do_reset();
        do_start();
        for (int i = 0; i < 16; i++) run_instr(16'h0000, 0, 0);
        check("wrap_w_zero", bus_w.instret, 4'd0);
        check("wrap_main", bus.instret, 16'd16);

        // Reset asserted during the MEM wait of an LD.
        do_reset();
        do_start();
        bus.instr_in = 16'h7000;
        mem_phase("mid_fetch", 0, 1'b1, 1'b1, ok);
        bus.mem_ready = 1'b0;
        e = base();
        e.busy = 1'b1;
        cyc("mid_decode", e);
        m_sel = 2'd1;
        e = base();
        e.busy   = 1'b1;
        e.mem_rd = 1'b1;
        cyc("mid_mem", e);
        rst = 1'b1;
        cyc("mid_mem_rst", e);
        rst = 1'b0;
        model_reset();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc("after_mid_rst", base());

        // Randomized instruction stream with random memory waits.
        do_reset();
        do_start();
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)      op = 4'hF;
            else if (r < 4) op = 4'($urandom_range(10, 14));
            else            op = 4'($urandom_range(0, 9));
            run_instr({op, 12'($urandom)},
                      ($urandom_range(0, 19) == 0) ? int'(T) : int'($urandom_range(0, 4)),
                      ($urandom_range(0, 19) == 0) ? int'(T) : int'($urandom_range(0, 4)));
            if (m_halted) begin
                do_reset();
                do_start();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
